// File: rtl/max7219_frame_scheduler.sv
// Register-write sequencer for two cascaded MAX7219 matrices: power-up init,
// per-frame row refresh from a pixel snapshot, and intensity updates between frames.
`default_nettype none

module max7219_frame_scheduler #(
  parameter logic [3:0] INIT_INTENSITY = 4'h8,
  parameter int         FRAME_PERIOD   = 2_500_000
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [127:0] pixels,
  input  logic         intensity_req,
  input  logic [3:0]   intensity,
  output logic [31:0]  word,
  output logic         word_valid,
  input  logic         word_ready,
  output logic         busy,
  output logic         frame_done
);

  localparam int             CW   = $clog2(FRAME_PERIOD);
  localparam logic [CW-1:0]  LAST = CW'(FRAME_PERIOD - 1);

  typedef enum logic [1:0] {
    INIT  = 2'd0,
    ROWS  = 2'd1,
    WAIT  = 2'd2,
    INTEN = 2'd3
  } state_t;

  state_t         state, state_nx;
  logic [2:0]     idx, idx_nx;
  logic [127:0]   snap, snap_nx;
  logic [CW-1:0]  cnt;
  logic           tick_pend, tick_clr;
  logic           inten_pend, inten_clr;
  logic [3:0]     inten_val;
  logic           accept, load, done_nx;
  logic [31:0]    word_nx;
  logic [2:0]     sel;
  logic [7:0]     row_addr;

  function automatic logic [15:0] init_pair(input logic [2:0] i);
    case (i)
      3'd0:    init_pair = 16'h0C01;
      3'd1:    init_pair = 16'h0900;
      3'd2:    init_pair = 16'h0B07;
      3'd3:    init_pair = {8'h0A, 4'h0, INIT_INTENSITY};
      default: init_pair = 16'h0F00;
    endcase
  endfunction

  assign accept = word_valid & word_ready;
  // A new word is loaded whenever the output slot is empty or being drained.
  assign load   = ~word_valid | accept;
  assign busy   = (state != WAIT);

  always_comb begin
    state_nx  = state;
    idx_nx    = idx;
    snap_nx   = snap;
    tick_clr  = 1'b0;
    inten_clr = 1'b0;
    done_nx   = 1'b0;
    case (state)
      INIT: begin
        if (accept) begin
          if (idx == 3'd4) begin
            state_nx = ROWS;
            idx_nx   = 3'd0;
            snap_nx  = pixels;
          end else begin
            idx_nx = idx + 3'd1;
          end
        end
      end
      ROWS: begin
        if (accept) begin
          if (idx == 3'd7) begin
            state_nx = WAIT;
            idx_nx   = 3'd0;
            done_nx  = 1'b1;
          end else begin
            idx_nx = idx + 3'd1;
          end
        end
      end
      INTEN: begin
        if (accept) begin
          state_nx  = WAIT;
          inten_clr = 1'b1;
        end
      end
      WAIT: begin
        if (inten_pend) begin
          state_nx = INTEN;
        end else if (tick_pend) begin
          state_nx = ROWS;
          idx_nx   = 3'd0;
          snap_nx  = pixels;
          tick_clr = 1'b1;
        end
      end
      default: state_nx = INIT;
    endcase
  end

  // Word for the state/index about to be presented; row 0 reads the top byte.
  always_comb begin
    word_nx  = word;
    sel      = 3'd7 - idx_nx;
    row_addr = {5'd0, idx_nx} + 8'd1;
    case (state_nx)
      INIT:  word_nx = {init_pair(idx_nx), init_pair(idx_nx)};
      ROWS:  word_nx = {row_addr, snap_nx[{1'b1, sel, 3'b000} +: 8],
                        row_addr, snap_nx[{1'b0, sel, 3'b000} +: 8]};
      INTEN: word_nx = {8'h0A, 4'h0, inten_val, 8'h0A, 4'h0, inten_val};
      default: word_nx = word;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state      <= INIT;
      idx        <= 3'd0;
      snap       <= '0;
      word       <= '0;
      word_valid <= 1'b0;
      frame_done <= 1'b0;
    end else begin
      state      <= state_nx;
      idx        <= idx_nx;
      snap       <= snap_nx;
      frame_done <= done_nx;
      if (load) begin
        word       <= word_nx;
        word_valid <= (state_nx != WAIT);
      end
    end
  end

  // A wrap coinciding with a clear re-arms the tick; a request beats a clear.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt        <= '0;
      tick_pend  <= 1'b0;
      inten_pend <= 1'b0;
      inten_val  <= 4'h0;
    end else begin
      if (cnt == LAST) begin
        cnt       <= '0;
        tick_pend <= 1'b1;
      end else begin
        cnt <= cnt + CW'(1);
        if (tick_clr) tick_pend <= 1'b0;
      end
      if (intensity_req) begin
        inten_pend <= 1'b1;
        inten_val  <= intensity;
      end else if (inten_clr) begin
        inten_pend <= 1'b0;
      end
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_max7219_frame_scheduler.sv
// Directed bench for max7219_frame_scheduler: vector table of frames plus
// hand sequences for backpressure, intensity priority, snapshot and reset.
`default_nettype none

module tb_max7219_frame_scheduler;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic [127:0] pixels = '0;
  logic         intensity_req = 1'b0;
  logic [3:0]   intensity = 4'h0;
  logic [31:0]  word;
  logic         word_valid;
  logic         word_ready = 1'b1;
  logic         busy;
  logic         frame_done;

  int checks = 0;
  int errors = 0;
  int fd_count = 0;
  int fd_double = 0;
  logic fd_prev = 1'b0;
  logic [31:0] acc[$];

  always #5 clk = ~clk;

  max7219_frame_scheduler #(
    .INIT_INTENSITY(4'h8),
    .FRAME_PERIOD  (16)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .pixels       (pixels),
    .intensity_req(intensity_req),
    .intensity    (intensity),
    .word         (word),
    .word_valid   (word_valid),
    .word_ready   (word_ready),
    .busy         (busy),
    .frame_done   (frame_done)
  );

  // Inputs change just after posedge, so a negedge sample predicts acceptance.
  always @(negedge clk) begin
    if (rst_n && word_valid && word_ready) acc.push_back(word);
    if (frame_done) begin
      fd_count++;
      if (fd_prev) fd_double++;
    end
    fd_prev = frame_done;
  end

  typedef struct {
    logic [127:0]     pix;
    logic [7:0][31:0] rows;
    bit               stall;
  } vec_t;

  vec_t        vecs[3];
  logic [31:0] init_exp[5];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic wait_words(input int n, input string tag);
    for (int i = 0; i < 400 && acc.size() < n; i++) begin
      @(negedge clk);
      #1;
    end
    checks++;
    if (acc.size() < n) begin
      errors++;
      $display("FAIL %s: timeout with %0d words, wanted %0d", tag, acc.size(), n);
    end
  endtask

  task automatic wait_fd(input string tag);
    int start;
    start = fd_count;
    for (int i = 0; i < 400 && fd_count == start; i++) begin
      @(negedge clk);
      #1;
    end
    checks++;
    if (fd_count == start) begin
      errors++;
      $display("FAIL %s: frame_done timeout", tag);
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    init_exp = '{32'h0C010C01, 32'h09000900, 32'h0B070B07, 32'h0A080A08, 32'h0F000F00};

    vecs[0].pix   = {64'h1c36363030307800, 64'h603c766666663c00};
    vecs[0].rows  = {32'h08000800, 32'h0778073C, 32'h06300666, 32'h05300566,
                     32'h04300466, 32'h03360376, 32'h0236023C, 32'h011C0160};
    vecs[0].stall = 1'b0;
    vecs[1].pix   = {128{1'b1}};
    vecs[1].rows  = {32'h08FF08FF, 32'h07FF07FF, 32'h06FF06FF, 32'h05FF05FF,
                     32'h04FF04FF, 32'h03FF03FF, 32'h02FF02FF, 32'h01FF01FF};
    vecs[1].stall = 1'b0;
    vecs[2].pix   = {64'h0123456789ABCDEF, 64'hFEDCBA9876543210};
    vecs[2].rows  = {32'h08EF0810, 32'h07CD0732, 32'h06AB0654, 32'h05890576,
                     32'h04670498, 32'h034503BA, 32'h022302DC, 32'h010101FE};
    vecs[2].stall = 1'b1;

    // Reset state and power-up sequence
    pixels = vecs[0].pix;
    repeat (3) @(posedge clk);
    #1;
    check("rst_word", word, 32'h0);
    check("rst_valid", {31'b0, word_valid}, 32'd0);
    check("rst_busy", {31'b0, busy}, 32'd1);
    check("rst_frame_done", {31'b0, frame_done}, 32'd0);
    rst_n = 1'b1;
    @(negedge clk);
    #1;
    check("pre_first_valid", {31'b0, word_valid}, 32'd0);
    @(negedge clk);
    #1;
    check("first_valid", {31'b0, word_valid}, 32'd1);
    check("first_word", word, 32'h0C010C01);
    wait_words(13, "init_frame");
    for (int i = 0; i < 5; i++) check($sformatf("init%0d", i), acc[i], init_exp[i]);
    for (int r = 0; r < 8; r++) check($sformatf("v0_row%0d", r + 1), acc[5 + r], vecs[0].rows[r]);
    wait_fd("fd_v0");
    check("wait_busy", {31'b0, busy}, 32'd0);
    check("wait_valid", {31'b0, word_valid}, 32'd0);

    // Table-driven frames, each started by the next tick
    for (int v = 1; v < 3; v++) begin
      pixels = vecs[v].pix;
      acc.delete();
      if (vecs[v].stall) begin
        wait_words(3, "stall_pre");
        @(posedge clk);
        #1;
        word_ready = 1'b0;
        for (int c = 0; c < 10; c++) begin
          @(negedge clk);
          #1;
          check($sformatf("stall_word%0d", c), word, vecs[v].rows[3]);
          check($sformatf("stall_valid%0d", c), {31'b0, word_valid}, 32'd1);
        end
        @(posedge clk);
        #1;
        word_ready = 1'b1;
      end
      wait_words(8, $sformatf("v%0d_frame", v));
      for (int r = 0; r < 8; r++)
        check($sformatf("v%0d_row%0d", v, r + 1), acc[r], vecs[v].rows[r]);
      wait_fd($sformatf("fd_v%0d", v));
    end

    // Intensity requests during a stalled frame, with a tick also pending
    pixels = vecs[0].pix;
    acc.delete();
    wait_words(1, "inten_pre");
    @(posedge clk);
    #1;
    word_ready    = 1'b0;
    intensity_req = 1'b1;
    intensity     = 4'h3;
    @(posedge clk);
    #1;
    intensity_req = 1'b0;
    repeat (6) @(posedge clk);
    #1;
    intensity_req = 1'b1;
    intensity     = 4'h5;
    @(posedge clk);
    #1;
    intensity_req = 1'b0;
    repeat (14) @(posedge clk);
    #1;
    word_ready = 1'b1;
    wait_fd("fd_inten");
    check("inten_busy", {31'b0, busy}, 32'd0);
    acc.delete();
    wait_words(2, "inten_words");
    check("inten_word", acc[0], 32'h0A050A05);
    check("after_inten_row1", acc[1], vecs[0].rows[0]);

    // Pixels change mid-frame; the snapshot keeps the old image
    wait_words(4, "snap_pre");
    pixels = vecs[1].pix;
    wait_words(9, "snap_frame");
    for (int r = 3; r < 8; r++) check($sformatf("snap_row%0d", r + 1), acc[1 + r], vecs[0].rows[r]);
    wait_fd("fd_snap");
    acc.delete();
    wait_words(1, "snap_next");
    check("next_frame_row1", acc[0], 32'h01FF01FF);

    // One-cycle reset during INIT idx 2
    @(posedge clk);
    #1;
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("init_idx2_word", word, 32'h0B070B07);
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    acc.delete();
    @(negedge clk);
    #1;
    check("midinit_rst_valid", {31'b0, word_valid}, 32'd0);
    wait_words(5, "reinit");
    for (int i = 0; i < 5; i++) check($sformatf("reinit%0d", i), acc[i], init_exp[i]);

    check("frame_done_single", fd_double[31:0], 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
